// File: rtl/ex_pkg.sv
// ex_pkg: shared opcode, branch-condition and FSM-state types for the execute stage
package ex_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } ex_op_e;
  typedef enum logic [2:0] {BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} br_cond_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} ex_state_e;
  function automatic logic is_multicycle(input ex_op_e op);
    return op inside {OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider on magnitudes
module muldiv_iter import ex_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_start,
  input  ex_op_e                i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);
  localparam int CW = $clog2(DATA_WIDTH);
  ex_state_e state, state_n;
  ex_op_e op;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] a, x, y, acc, q, dsub;
  logic [DATA_WIDTH:0] sh;
  logic neg_q, neg_r, b_zero, a_neg, b_neg, ge, is_div;
  assign a_neg = (i_op == OP_DIV || i_op == OP_REM) && i_a[DATA_WIDTH-1];
  assign b_neg = (i_op == OP_DIV || i_op == OP_REM) && i_b[DATA_WIDTH-1];
  assign sh = {acc, x[cnt]};
  assign ge = sh >= {1'b0, y};
  assign dsub = sh[DATA_WIDTH-1:0] - y;
  assign is_div = op == OP_DIV || op == OP_DIVU;
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
  // next state: start leaves IDLE, counter exhaustion ends BUSY, DONE lasts one cycle
  always_comb begin
    state_n = state;
    state_n = i_flush ? IDLE :
              state == IDLE ? (i_start ? BUSY : IDLE) :
              state == BUSY ? (cnt == '0 ? DONE : BUSY) : IDLE;
  end
  // restore signs; divide by zero and MIN/-1 fall out as the architected values
  always_comb begin
    o_result = acc;
    if (op != OP_MUL)
      o_result = b_zero ? (is_div ? '1 : a) : is_div ? (neg_q ? -q : q) : (neg_r ? -acc : acc);
  end
  // state register and bit counter
  always_ff @(posedge i_clk)
    if (i_reset || i_flush) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == IDLE && i_start) ? CW'(DATA_WIDTH - 1) :
             (state == BUSY && cnt != '0) ? cnt - 1'b1 : cnt;
    end
  // capture magnitudes at start, then retire one operand bit per BUSY cycle
  always_ff @(posedge i_clk)
    if (state == IDLE && i_start) begin
      op <= i_op;
      a <= i_a;
      x <= a_neg ? -i_a : i_a;
      y <= b_neg ? -i_b : i_b;
      acc <= '0;
      q <= '0;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      b_zero <= i_b == '0;
    end else if (state == BUSY) begin
      acc <= op == OP_MUL ? (acc << 1) + (x[cnt] ? y : '0) : ge ? dsub : sh[DATA_WIDTH-1:0];
      q[cnt] <= ge;
    end
endmodule

// File: rtl/execute_stage_mc.sv
// execute_stage_mc: EX stage with single-cycle ALU, iterative mul/div, branch compare and PC adder
module execute_stage_mc import ex_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter bit MULDIV_EN  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  ex_op_e                i_op,
  input  logic                  i_alu_src_sel,
  input  logic                  i_br_en,
  input  br_cond_e              i_br_cond,
  input  logic [DATA_WIDTH-1:0] i_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
  input  logic [PC_WIDTH-1:0]   i_imm,
  input  logic [PC_WIDTH-1:0]   i_pc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [DATA_WIDTH-1:0] o_store_data,
  output logic [PC_WIDTH-1:0]   o_pc_target,
  output logic                  o_br_taken,
  output logic                  o_zero
);
  localparam int SW = $clog2(DATA_WIDTH);
  logic accept, mc, md_busy, md_done, eq, lt, ltu, cond, pend_br;
  logic [DATA_WIDTH-1:0] b, alu, md_result, pend_store;
  logic [PC_WIDTH-1:0] pc_t, pend_pc;
  logic [SW-1:0] shamt;
  assign b = i_alu_src_sel ? DATA_WIDTH'($signed(i_imm)) : i_rs2_data;
  assign shamt = b[SW-1:0];
  assign mc = MULDIV_EN && is_multicycle(i_op);
  assign o_ready = !md_busy && (!o_valid || i_ready);
  assign accept = i_valid && o_ready && !i_flush;
  assign pc_t = i_pc + i_imm;
  assign eq = i_rs1_data == i_rs2_data;
  assign lt = $signed(i_rs1_data) < $signed(i_rs2_data);
  assign ltu = i_rs1_data < i_rs2_data;
  // single-cycle ALU; mul/div opcodes yield 0 here
  always_comb begin
    alu = '0;
    case (i_op)
      OP_ADD:  alu = i_rs1_data + b;
      OP_SUB:  alu = i_rs1_data - b;
      OP_AND:  alu = i_rs1_data & b;
      OP_OR:   alu = i_rs1_data | b;
      OP_XOR:  alu = i_rs1_data ^ b;
      OP_SLL:  alu = i_rs1_data << shamt;
      OP_SRL:  alu = i_rs1_data >> shamt;
      OP_SRA:  alu = $signed(i_rs1_data) >>> shamt;
      OP_SLT:  alu = DATA_WIDTH'($signed(i_rs1_data) < $signed(b));
      OP_SLTU: alu = DATA_WIDTH'(i_rs1_data < b);
      default: alu = '0;
    endcase
  end
  // branch condition select on rs1/rs2
  always_comb begin
    cond = 1'b0;
    cond = i_br_cond == BR_EQ  ? eq  : i_br_cond == BR_NE ? !eq :
           i_br_cond == BR_LT  ? lt  : i_br_cond == BR_GE ? !lt :
           i_br_cond == BR_LTU ? ltu : !ltu;
  end
  if (MULDIV_EN) begin : g_md
    muldiv_iter #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
      .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_start(accept && mc),
      .i_op(i_op), .i_a(i_rs1_data), .i_b(b),
      .o_busy(md_busy), .o_done(md_done), .o_result(md_result)
    );
  end else begin : g_no_md
    assign md_busy = 1'b0;
    assign md_done = 1'b0;
    assign md_result = '0;
  end
  // side results of an iterative op wait here until its result lands
  always_ff @(posedge i_clk)
    if (accept) begin
      pend_store <= i_rs2_data;
      pend_pc <= pc_t;
      pend_br <= i_br_en && cond;
    end
  // output slot: load on completion, hold under backpressure, drop when consumed
  always_ff @(posedge i_clk)
    if (i_reset || i_flush) begin
      o_valid <= 1'b0;
      o_result <= '0;
      o_store_data <= '0;
      o_pc_target <= '0;
      o_br_taken <= 1'b0;
      o_zero <= 1'b0;
    end else if (md_done) begin
      o_valid <= 1'b1;
      o_result <= md_result;
      o_zero <= md_result == '0;
      o_store_data <= pend_store;
      o_pc_target <= pend_pc;
      o_br_taken <= pend_br;
    end else if (accept && !mc) begin
      o_valid <= 1'b1;
      o_result <= alu;
      o_zero <= alu == '0;
      o_store_data <= i_rs2_data;
      o_pc_target <= pc_t;
      o_br_taken <= i_br_en && cond;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
endmodule

// File: tb/tb_execute_stage_mc.sv
// tb_execute_stage_mc: directed vector table plus multi-cycle corner sequences
module tb_execute_stage_mc;
  import ex_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic i_reset, i_flush, i_valid, o_ready, i_alu_src_sel, i_br_en, o_valid, i_ready, o_br_taken, o_zero;
  ex_op_e i_op;
  br_cond_e i_br_cond;
  logic [31:0] i_rs1_data, i_rs2_data, i_imm, i_pc, o_result, o_store_data, o_pc_target;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    ex_op_e op; logic src; logic br_en; br_cond_e cond;
    logic [31:0] a, b, imm, pc, res; logic zero, br; logic [31:0] tgt;
  } vec_t;
  vec_t vecs[19];

  execute_stage_mc dut (
    .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_alu_src_sel(i_alu_src_sel), .i_br_en(i_br_en), .i_br_cond(i_br_cond),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm), .i_pc(i_pc),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_store_data(o_store_data),
    .o_pc_target(o_pc_target), .o_br_taken(o_br_taken), .o_zero(o_zero)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input ex_op_e op, input logic [31:0] a, input logic [31:0] b);
    i_op = op; i_rs1_data = a; i_rs2_data = b;
    i_alu_src_sel = 1'b0; i_br_en = 1'b0; i_br_cond = BR_EQ; i_imm = '0; i_pc = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " o_valid"}, 32'(o_valid), 32'd0);
    chk({tag, " o_ready"}, 32'(o_ready), 32'd1);
    chk({tag, " o_result"}, o_result, 32'd0);
    chk({tag, " o_store_data"}, o_store_data, 32'd0);
    chk({tag, " o_pc_target"}, o_pc_target, 32'd0);
    chk({tag, " o_br_taken"}, 32'(o_br_taken), 32'd0);
    chk({tag, " o_zero"}, 32'(o_zero), 32'd0);
  endtask

  task automatic no_valid_for(input string tag, input int n);
    int seen = 0;
    for (int k = 0; k < n; k++) begin
      step;
      if (o_valid) seen++;
    end
    chk({tag, " stray o_valid"}, 32'(seen), 32'd0);
  endtask

  task automatic run_mc(input string name, input ex_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat = 0, low = 0;
    issue(op, a, b);
    i_br_en = 1'b1; i_pc = 32'h200; i_imm = 32'd4; i_valid = 1'b1; i_ready = 1'b1;
    step;
    issue(OP_ADD, 32'h0, 32'h1234);
    while (!o_valid && lat < 100) begin
      if (!o_ready) low++;
      step;
      lat++;
    end
    i_valid = 1'b0;
    chk({name, " latency"}, 32'(lat), 32'd33);
    chk({name, " ready low"}, 32'(low), 32'd33);
    chk({name, " result"}, o_result, exp);
    chk({name, " zero"}, 32'(o_zero), 32'(exp == 32'd0));
    chk({name, " store"}, o_store_data, b);
    chk({name, " target"}, o_pc_target, 32'h204);
    chk({name, " br"}, 32'(o_br_taken), 32'(a == b));
    chk({name, " ready after"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{OP_ADD,  1'b0, 1'b0, BR_EQ,  32'd5, 32'd7, 32'd0, 32'd0, 32'd12, 1'b0, 1'b0, 32'd0};
    vecs[1]  = '{OP_SUB,  1'b0, 1'b0, BR_EQ,  32'd9, 32'd9, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0};
    vecs[2]  = '{OP_SRA,  1'b0, 1'b0, BR_EQ,  32'h80000000, 32'd4, 32'd0, 32'd0, 32'hF8000000, 1'b0, 1'b0, 32'd0};
    vecs[3]  = '{OP_SRL,  1'b0, 1'b0, BR_EQ,  32'h80000000, 32'd4, 32'd0, 32'd0, 32'h08000000, 1'b0, 1'b0, 32'd0};
    vecs[4]  = '{OP_SLL,  1'b1, 1'b0, BR_EQ,  32'd1, 32'd0, 32'd31, 32'h10, 32'h80000000, 1'b0, 1'b0, 32'h2F};
    vecs[5]  = '{OP_AND,  1'b0, 1'b0, BR_EQ,  32'hF0F0, 32'hFF00, 32'd0, 32'd0, 32'hF000, 1'b0, 1'b0, 32'd0};
    vecs[6]  = '{OP_OR,   1'b0, 1'b0, BR_EQ,  32'hF0F0, 32'h0F0F, 32'd0, 32'd0, 32'hFFFF, 1'b0, 1'b0, 32'd0};
    vecs[7]  = '{OP_XOR,  1'b0, 1'b0, BR_EQ,  32'hFFFF, 32'hFFFF, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0};
    vecs[8]  = '{OP_SLT,  1'b0, 1'b0, BR_EQ,  32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd1, 1'b0, 1'b0, 32'd0};
    vecs[9]  = '{OP_SLTU, 1'b0, 1'b0, BR_EQ,  32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0};
    vecs[10] = '{OP_SUB,  1'b0, 1'b1, BR_LT,  32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 32'hFFFFFFFE, 1'b0, 1'b1, 32'h120};
    vecs[11] = '{OP_SUB,  1'b0, 1'b1, BR_GEU, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFE, 1'b0, 1'b1, 32'd0};
    vecs[12] = '{OP_SUB,  1'b0, 1'b1, BR_EQ,  32'd3, 32'd4, 32'h20, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h10};
    vecs[13] = '{OP_ADD,  1'b0, 1'b0, BR_EQ,  32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0};
    vecs[14] = '{OP_SLL,  1'b0, 1'b0, BR_EQ,  32'd1, 32'd33, 32'd0, 32'd0, 32'd2, 1'b0, 1'b0, 32'd0};
    vecs[15] = '{OP_SUB,  1'b0, 1'b1, BR_GE,  32'd1, 32'hFFFFFFFF, 32'd8, 32'd0, 32'd2, 1'b0, 1'b1, 32'd8};
    vecs[16] = '{OP_SUB,  1'b0, 1'b1, BR_LTU, 32'd1, 32'hFFFFFFFF, 32'd8, 32'd0, 32'd2, 1'b0, 1'b1, 32'd8};
    vecs[17] = '{OP_ADD,  1'b0, 1'b1, BR_NE,  32'd5, 32'd5, 32'd0, 32'd0, 32'd10, 1'b0, 1'b0, 32'd0};
    vecs[18] = '{OP_ADD,  1'b0, 1'b0, BR_EQ,  32'd4, 32'd4, 32'd0, 32'd0, 32'd8, 1'b0, 1'b0, 32'd0};
    i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    issue(OP_ADD, 32'd0, 32'd0);
    repeat (2) step;
    i_reset = 1'b0;
    chk_reset("reset");
    for (int i = 0; i < 19; i++) begin
      i_op = vecs[i].op; i_alu_src_sel = vecs[i].src; i_br_en = vecs[i].br_en; i_br_cond = vecs[i].cond;
      i_rs1_data = vecs[i].a; i_rs2_data = vecs[i].b; i_imm = vecs[i].imm; i_pc = vecs[i].pc;
      i_valid = 1'b1;
      step;
      i_valid = 1'b0;
      chk($sformatf("v%0d valid", i), 32'(o_valid), 32'd1);
      chk($sformatf("v%0d result", i), o_result, vecs[i].res);
      chk($sformatf("v%0d zero", i), 32'(o_zero), 32'(vecs[i].zero));
      chk($sformatf("v%0d br", i), 32'(o_br_taken), 32'(vecs[i].br));
      chk($sformatf("v%0d target", i), o_pc_target, vecs[i].tgt);
      chk($sformatf("v%0d store", i), o_store_data, vecs[i].b);
    end
    step;
    chk("drain valid", 32'(o_valid), 32'd0);
    run_mc("mul ffff", OP_MUL, 32'hFFFF, 32'hFFFF, 32'hFFFE0001);
    run_mc("mul neg", OP_MUL, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD);
    run_mc("mul zero", OP_MUL, 32'd0, 32'd5, 32'd0);
    run_mc("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_mc("rem -7/2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_mc("div 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
    run_mc("rem 7/-2", OP_REM, 32'd7, 32'hFFFFFFFE, 32'd1);
    run_mc("divu x/0", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF);
    run_mc("div -5/0", OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF);
    run_mc("rem -5/0", OP_REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB);
    run_mc("remu 7/0", OP_REMU, 32'd7, 32'd0, 32'd7);
    run_mc("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_mc("rem min/-1", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    run_mc("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14);
    run_mc("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2);
    step;
    issue(OP_ADD, 32'd1, 32'd2);
    i_valid = 1'b1; i_ready = 1'b0;
    step;
    chk("bp first valid", 32'(o_valid), 32'd1);
    issue(OP_SUB, 32'd10, 32'd4);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp hold%0d result", k), o_result, 32'd3);
      chk($sformatf("bp hold%0d ready", k), 32'(o_ready), 32'd0);
      chk($sformatf("bp hold%0d valid", k), 32'(o_valid), 32'd1);
      step;
    end
    i_ready = 1'b1;
    #1;
    chk("bp ready on i_ready", 32'(o_ready), 32'd1);
    step;
    i_valid = 1'b0;
    chk("bp next result", o_result, 32'd6);
    chk("bp next valid", 32'(o_valid), 32'd1);
    step;
    chk("bp drained", 32'(o_valid), 32'd0);
    issue(OP_DIV, 32'd100, 32'd7);
    i_valid = 1'b1;
    step;
    i_valid = 1'b0;
    repeat (9) step;
    chk("flush busy ready", 32'(o_ready), 32'd0);
    i_flush = 1'b1;
    step;
    i_flush = 1'b0;
    chk("flush valid", 32'(o_valid), 32'd0);
    chk("flush ready", 32'(o_ready), 32'd1);
    no_valid_for("flush", 40);
    issue(OP_ADD, 32'd1, 32'd1);
    i_valid = 1'b1; i_flush = 1'b1;
    step;
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush beats accept", 32'(o_valid), 32'd0);
    issue(OP_ADD, 32'd2, 32'd2);
    i_valid = 1'b1; i_ready = 1'b0;
    step;
    i_valid = 1'b0;
    chk("slot before flush", 32'(o_valid), 32'd1);
    i_flush = 1'b1;
    step;
    i_flush = 1'b0; i_ready = 1'b1;
    chk("slot flushed", 32'(o_valid), 32'd0);
    issue(OP_MUL, 32'd3, 32'd5);
    i_valid = 1'b1;
    step;
    i_valid = 1'b0;
    repeat (4) step;
    i_reset = 1'b1;
    step;
    i_reset = 1'b0;
    chk_reset("busy reset");
    no_valid_for("busy reset", 40);
    issue(OP_ADD, 32'd20, 32'd22);
    i_valid = 1'b1;
    step;
    i_valid = 1'b0;
    chk("after reset result", o_result, 32'd42);
    chk("after reset valid", 32'(o_valid), 32'd1);
    step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
